// File: rtl/run_length_detector.sv
// Serial run-length detector: flags when ACTIVE has been sampled RUN_LEN times in a row,
// tracks the current run length and counts completed runs.
module run_length_detector #(
    parameter int   RUN_LEN = 2,
    parameter logic ACTIVE  = 1'b1,
    parameter int   MODE    = 0,
    parameter int   CNT_W   = 8,
    parameter int   HIT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             w_i,
    output logic             z_o,
    output logic [CNT_W-1:0] run_o,
    output logic [HIT_W-1:0] hit_cnt_o
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HIT
    } state_t;

    localparam logic [CNT_W-1:0] RUN_MAX = '1;
    localparam logic [HIT_W-1:0] HIT_MAX = '1;
    localparam logic [CNT_W-1:0] LEN     = CNT_W'(RUN_LEN);
    localparam logic [CNT_W-1:0] LEN_M1  = CNT_W'(RUN_LEN - 1);

    state_t           r_state;
    state_t           w_stateNext;
    logic [CNT_W-1:0] r_run;
    logic [CNT_W-1:0] w_runNext;
    logic [HIT_W-1:0] r_hitCnt;
    logic [HIT_W-1:0] w_hitCntNext;
    logic             r_z;
    logic             w_z;
    logic             w_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_run    <= '0;
            r_hitCnt <= '0;
            r_z      <= 1'b0;
        end else begin
            r_state  <= w_stateNext;
            r_run    <= w_runNext;
            r_hitCnt <= w_hitCntNext;
            r_z      <= w_z;
        end
    end

    // A hit is the sample that lifts the run from RUN_LEN-1 to RUN_LEN; a saturated
    // run can never fall back onto RUN_LEN-1, so PULSE mode cannot re-trigger.
    always_comb begin
        w_stateNext  = r_state;
        w_runNext    = r_run;
        w_hitCntNext = r_hitCnt;
        w_z          = 1'b0;
        w_hit        = 1'b0;
        if (clr_i) begin
            w_stateNext  = IDLE;
            w_runNext    = '0;
            w_hitCntNext = '0;
        end else if (en_i) begin
            if (w_i == ACTIVE) begin
                w_runNext = (r_run == RUN_MAX) ? r_run : r_run + 1'b1;
                w_hit     = (r_run == LEN_M1);
                w_z       = (MODE == 1) ? w_hit : (r_run >= LEN_M1);
                case (r_state)
                    IDLE:    w_stateNext = (RUN_LEN == 1) ? HIT : RUN;
                    RUN:     w_stateNext = (w_runNext == LEN) ? HIT : RUN;
                    HIT:     w_stateNext = HIT;
                    default: w_stateNext = IDLE;
                endcase
                if (w_hit && (r_hitCnt != HIT_MAX)) begin
                    w_hitCntNext = r_hitCnt + 1'b1;
                end
            end else begin
                w_stateNext = IDLE;
                w_runNext   = '0;
            end
        end
    end

    assign z_o       = r_z;
    assign run_o     = r_run;
    assign hit_cnt_o = r_hitCnt;

endmodule

// File: tb/tb_run_length_detector.sv
// Bench for run_length_detector: five configurations share one stimulus stream and are
// checked every cycle against a streak-counting model, plus directed literal scenarios.
module tb_run_length_detector;

    localparam int NI = 5;
    localparam int RL  [NI] = '{2, 3, 1, 3, 2};
    localparam int ACT [NI] = '{1, 1, 0, 1, 1};
    localparam int MD  [NI] = '{0, 1, 0, 0, 0};
    localparam int CW  [NI] = '{8, 8, 8, 8, 3};
    localparam int HW  [NI] = '{16, 16, 16, 16, 2};

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic clr = 1'b0;
    logic en = 1'b0;
    logic w = 1'b0;
    logic checkOn = 1'b0;

    logic [NI-1:0]       dZ;
    logic [NI-1:0][15:0] dRun;
    logic [NI-1:0][15:0] dHit;

    logic [7:0]  run0, run1, run2, run3;
    logic [2:0]  run4;
    logic [15:0] hit0, hit1, hit2, hit3;
    logic [1:0]  hit4;

    int nCompared = 0;
    int nMismatched = 0;

    int mStreak [NI];
    int mHits   [NI];
    int mZ      [NI];

    always #5 clk = ~clk;

    run_length_detector #(.RUN_LEN(2), .ACTIVE(1'b1), .MODE(0), .CNT_W(8), .HIT_W(16)) u0 (
        .clk(clk), .rst_n(rst_n), .clr_i(clr), .en_i(en), .w_i(w),
        .z_o(dZ[0]), .run_o(run0), .hit_cnt_o(hit0));
    run_length_detector #(.RUN_LEN(3), .ACTIVE(1'b1), .MODE(1), .CNT_W(8), .HIT_W(16)) u1 (
        .clk(clk), .rst_n(rst_n), .clr_i(clr), .en_i(en), .w_i(w),
        .z_o(dZ[1]), .run_o(run1), .hit_cnt_o(hit1));
    run_length_detector #(.RUN_LEN(1), .ACTIVE(1'b0), .MODE(0), .CNT_W(8), .HIT_W(16)) u2 (
        .clk(clk), .rst_n(rst_n), .clr_i(clr), .en_i(en), .w_i(w),
        .z_o(dZ[2]), .run_o(run2), .hit_cnt_o(hit2));
    run_length_detector #(.RUN_LEN(3), .ACTIVE(1'b1), .MODE(0), .CNT_W(8), .HIT_W(16)) u3 (
        .clk(clk), .rst_n(rst_n), .clr_i(clr), .en_i(en), .w_i(w),
        .z_o(dZ[3]), .run_o(run3), .hit_cnt_o(hit3));
    run_length_detector #(.RUN_LEN(2), .ACTIVE(1'b1), .MODE(0), .CNT_W(3), .HIT_W(2)) u4 (
        .clk(clk), .rst_n(rst_n), .clr_i(clr), .en_i(en), .w_i(w),
        .z_o(dZ[4]), .run_o(run4), .hit_cnt_o(hit4));

    assign dRun[0] = {8'b0, run0};
    assign dRun[1] = {8'b0, run1};
    assign dRun[2] = {8'b0, run2};
    assign dRun[3] = {8'b0, run3};
    assign dRun[4] = {13'b0, run4};
    assign dHit[0] = hit0;
    assign dHit[1] = hit1;
    assign dHit[2] = hit2;
    assign dHit[3] = hit3;
    assign dHit[4] = {14'b0, hit4};

    // Model keeps the true (unbounded) streak length; saturation is applied only when
    // the visible run value is formed, so "streak == RUN_LEN" happens once per run.
    function automatic bit sampledActive(int i);
        return !clr && en && (int'(w) == ACT[i]);
    endfunction

    function automatic int nStreak(int i);
        if (clr) return 0;
        if (!en) return mStreak[i];
        if (int'(w) == ACT[i]) return mStreak[i] + 1;
        return 0;
    endfunction

    function automatic int nZ(int i);
        if (!sampledActive(i)) return 0;
        if (MD[i] == 1) return (mStreak[i] + 1 == RL[i]) ? 1 : 0;
        return (mStreak[i] + 1 >= RL[i]) ? 1 : 0;
    endfunction

    function automatic int nHits(int i);
        int hmax;
        hmax = (1 << HW[i]) - 1;
        if (clr) return 0;
        if (sampledActive(i) && (mStreak[i] + 1 == RL[i]) && (mHits[i] < hmax))
            return mHits[i] + 1;
        return mHits[i];
    endfunction

    function automatic int expRun(int i);
        int rmax;
        rmax = (1 << CW[i]) - 1;
        return (mStreak[i] > rmax) ? rmax : mStreak[i];
    endfunction

    // Reference model state advances on the same edges as the DUT.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NI; i++) begin
                mStreak[i] <= 0;
                mHits[i]   <= 0;
                mZ[i]      <= 0;
            end
        end else begin
            for (int i = 0; i < NI; i++) begin
                mStreak[i] <= nStreak(i);
                mHits[i]   <= nHits(i);
                mZ[i]      <= nZ(i);
            end
        end
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        nCompared++;
        if (act != exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of all instances against the model, away from the rising edge.
    always @(negedge clk) begin
        if (checkOn) begin
            for (int i = 0; i < NI; i++) begin
                checkOutput($sformatf("model_z[%0d]", i), int'(dZ[i]), mZ[i]);
                checkOutput($sformatf("model_run[%0d]", i), int'(dRun[i]), expRun(i));
                checkOutput($sformatf("model_hit[%0d]", i), int'(dHit[i]), mHits[i]);
            end
        end
    end

    // One sampled cycle: drive inputs, take the rising edge, settle just after it.
    task automatic applyStimulus(input logic enV, input logic wV, input logic clrV);
        en  = enV;
        w   = wV;
        clr = clrV;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [6:0] legacyW;
        logic [6:0] zMask7;
        logic [5:0] zMask6;
        logic [4:0] zMask5;
        logic [4:0] gapEn;
        logic [3:0] polW;
        int gapRun [5];
        int runAfter4;
        int pct;

        legacyW = 7'b0101110;
        gapEn   = 5'b11011;
        polW    = 4'b0010;
        gapRun  = '{1, 2, 2, 3, 4};

        #1 rst_n = 1'b0;
        checkOn = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            checkOutput($sformatf("reset_run[%0d]", i), int'(dRun[i]), 0);
            checkOutput($sformatf("reset_hit[%0d]", i), int'(dHit[i]), 0);
        end
        #2 rst_n = 1'b1;

        // Legacy two-in-a-row behaviour.
        applyStimulus(1'b1, 1'b0, 1'b1);
        zMask7 = '0;
        runAfter4 = -1;
        for (int k = 0; k < 7; k++) begin
            applyStimulus(1'b1, legacyW[k], 1'b0);
            zMask7[k] = dZ[0];
            if (k == 4) runAfter4 = int'(dRun[0]);
        end
        checkOutput("legacy_zmask", int'(zMask7), int'(7'b0001100));
        checkOutput("legacy_hit", int'(dHit[0]), 1);
        checkOutput("legacy_run_after4", runAfter4, 0);

        // Pulse mode, RUN_LEN=3.
        applyStimulus(1'b1, 1'b0, 1'b1);
        zMask6 = '0;
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b0);
            zMask6[k] = dZ[1];
        end
        checkOutput("pulse_zmask", int'(zMask6), int'(6'b000100));
        checkOutput("pulse_hit", int'(dHit[1]), 1);
        checkOutput("pulse_run", int'(dRun[1]), 6);

        // Enable gap inside a run, RUN_LEN=3 level mode.
        applyStimulus(1'b1, 1'b0, 1'b1);
        zMask5 = '0;
        for (int k = 0; k < 5; k++) begin
            applyStimulus(gapEn[k], 1'b1, 1'b0);
            zMask5[k] = dZ[3];
            checkOutput($sformatf("gap_run_step%0d", k), int'(dRun[3]), gapRun[k]);
        end
        checkOutput("gap_zmask", int'(zMask5), int'(5'b11000));

        // Inverted polarity with RUN_LEN=1, then synchronous clear.
        applyStimulus(1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) applyStimulus(1'b1, polW[k], 1'b0);
        checkOutput("pol_hit", int'(dHit[2]), 2);
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("clr_hit", int'(dHit[2]), 0);
        checkOutput("clr_run", int'(dRun[2]), 0);
        checkOutput("clr_z", int'(dZ[2]), 0);

        // Saturation of run length and hit counter in the narrow instance.
        applyStimulus(1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 10; k++) applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("sat_run", int'(dRun[4]), 7);
        checkOutput("sat_z", int'(dZ[4]), 1);
        applyStimulus(1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b0);
            applyStimulus(1'b1, 1'b1, 1'b0);
            applyStimulus(1'b1, 1'b0, 1'b0);
        end
        checkOutput("sat_hit", int'(dHit[4]), 3);

        // Asynchronous reset mid-run.
        applyStimulus(1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("arst_pre_run", int'(dRun[0]), 1);
        rst_n = 1'b0;
        #1;
        checkOutput("arst_run", int'(dRun[0]), 0);
        checkOutput("arst_z", int'(dZ[0]), 0);
        checkOutput("arst_hit", int'(dHit[0]), 0);
        #2 rst_n = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("arst_first_z", int'(dZ[0]), 0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("arst_second_z", int'(dZ[0]), 1);
        checkOutput("arst_hit_after", int'(dHit[0]), 1);

        // Randomised traffic with varying density of active bits.
        pct = 50;
        for (int c = 0; c < 3000; c++) begin
            if ((c % 200) == 0) begin
                case ($urandom_range(0, 2))
                    0:       pct = 50;
                    1:       pct = 90;
                    default: pct = 99;
                endcase
            end
            if ($urandom_range(0, 499) == 0) begin
                rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
            applyStimulus($urandom_range(0, 9) != 0,
                          $urandom_range(0, 99) < pct,
                          $urandom_range(0, 99) == 0);
        end

        checkOn = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/run_length_detector.md
# run_length_detector

Parametrised serial run-length detector. Samples a 1-bit stream `w_i` and flags when the configured bit value has appeared on `RUN_LEN` consecutive sampled cycles. The flag is registered, one cycle after the completing sample. It is the general successor to the fixed two-in-a-row detector and adds the following:
- configurable run length and polarity;
- level or pulse output mode;
- a sample enable and a synchronous clear;
- a current-run length output and a saturating hit counter.

## Interface
- `RUN_LEN`, 2, consecutive active samples required for a hit; legal range 1 to 2^`CNT_W`-2.
- `ACTIVE`, 1'b1, bit value that counts toward a run.
- `MODE`, 0, 0 = LEVEL (flag stays high while the run continues), 1 = PULSE (one flag per run).
- `CNT_W`, 8, width of the run-length register and `run_o`.
- `HIT_W`, 16, width of the hit counter `hit_cnt_o`.

- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `clr_i`  in  1  synchronous clear; takes priority over `en_i`.
- `en_i`  in  1  sample enable; `w_i` is ignored when low.
- `w_i`  in  1  serial input bit.
- `z_o`  out  1  registered detect flag.
- `run_o`  out  `CNT_W`  current consecutive-active count, saturating.
- `hit_cnt_o`  out  `HIT_W`  number of runs that reached `RUN_LEN`, saturating.

## Operation
- **State register.** Holds `run` (0 to 2^`CNT_W`-1) and an FSM state derived from it:
  - IDLE: `run` = 0.
  - RUN: 0 < `run` < `RUN_LEN`.
  - HIT: `run` >= `RUN_LEN`.
- **Sampled cycle** (`en_i`=1, `clr_i`=0):
  - If `w_i`==`ACTIVE`: `run` <= `run`+1, saturating at all-ones.
    - IDLE goes to RUN, or to HIT directly when `RUN_LEN`=1.
    - RUN goes to HIT when the new value equals `RUN_LEN`.
    - HIT stays in HIT.
  - If `w_i`!=`ACTIVE`: `run` <= 0 and the state returns to IDLE from any state.
- **Unsampled cycle** (`en_i`=0): `run` and the state are held, so the run is not broken; `z` = 0.
- **Combinational Mealy term `z`**, evaluated on sampled cycles with an active bit only:
  - LEVEL: `z` = (`run` >= `RUN_LEN`-1).
  - PULSE: `z` = (`run` == `RUN_LEN`-1). This is true only on the sample that first completes the run.
- **Hit event:** the same condition as PULSE-mode `z`, independent of `MODE`. Each hit increments `hit_cnt_o`, which saturates at all-ones and never wraps.
- **Outputs:** `z_o` <= `z` on each rising edge. `run_o` is the `run` register.
- **`clr_i`=1:** `run` <= 0, state <= IDLE, `hit_cnt_o` <= 0, `z_o` <= 0. `en_i` and `w_i` are ignored that cycle.
- **Reset** (`rst_n` low, asynchronous): `run_o`=0, state IDLE, `z_o`=0, `hit_cnt_o`=0. An assertion mid-run discards the run. After release, counting restarts from 0.
- **Equivalence:** `RUN_LEN`=2, `ACTIVE`=1, `MODE`=0 with `en_i` tied high reproduces the legacy two-consecutive-ones detector exactly.

## Timing
- **Latency:** if the `RUN_LEN`-th consecutive active sample is presented in cycle k, `z_o` is high in cycle k+1.
- **LEVEL mode:** `z_o` stays high for each further active sample (cycle j implies `z_o` high in j+1). It drops one cycle after the first inactive or unsampled cycle.
- **PULSE mode:** `z_o` is high for exactly one cycle per run. No re-trigger occurs while `run` stays >= `RUN_LEN`, including after saturation.
- **`run_o`** reflects the sample of cycle k in cycle k+1.
- **`hit_cnt_o`** updates in the same cycle as `z_o` rises.
- **Enable gap inside a run:** `z_o` is 0 in the cycle after each `en_i`=0 cycle. The run resumes afterwards. In PULSE mode a gap never causes a second pulse.
- **Back-to-back runs:** a single inactive sample between two qualifying runs gives two separate hits, two PULSE flags and `hit_cnt_o`+2.
- **Saturation:** `run_o` holds at 2^`CNT_W`-1 on continued active input. In LEVEL mode `z_o` stays high.

## Test plan
- **Reset and legacy behaviour.** `RUN_LEN`=2, LEVEL, `en_i`=1, `w_i` = 0,1,1,1,0,1,0 (cycles 0 to 6) -> `z_o` high in cycles 3 and 4 only, `hit_cnt_o`=1, `run_o`=0 after cycle 4.
- **Pulse mode.** `RUN_LEN`=3, PULSE, `w_i` high for 6 cycles starting at cycle 0 -> `z_o` high in cycle 3 only, `hit_cnt_o`=1, `run_o`=6 at cycle 6.
- **Enable gap.** `RUN_LEN`=3, LEVEL, `w_i`=1 constant, `en_i` = 1,1,0,1,1 -> `run_o` sequence 1,2,2,3,4. `z_o` high in cycles 4 and 5 only.
- **Polarity, `RUN_LEN`=1, and clear.** `ACTIVE`=0, `w_i` = 0,1,0,0 -> `hit_cnt_o`=2. Then `clr_i`=1 together with `w_i`=0 -> next cycle `hit_cnt_o`=0, `run_o`=0, `z_o`=0.
- **Saturation.** `CNT_W`=3, `HIT_W`=2, `RUN_LEN`=2:
  - 10 active samples -> `run_o` holds at 7.
  - Five separate runs of 2 -> `hit_cnt_o` holds at 3.
- **Asynchronous reset mid-run.** Drop `rst_n` mid-cycle after 1 of 2 required samples -> all outputs 0 immediately. After release, `z_o` needs 2 fresh active samples before it rises.
